// File: rtl/text_screen_ctrl.sv
// Game-screen sequencer (TITLE -> COUNT -> PLAY -> OVER) and shared font-ROM
// arbiter for the text overlays. The overlay request is delayed one cycle so
// it lines up with the synchronous font ROM read data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_TITLE | title screen, waiting for a start press
// S_COUNT | countdown, digit steps down every FRAMES_PER_SEC frame ticks
// S_PLAY  | game running, waiting for a crash
// S_OVER  | game over, start press accepted once the hold time has passed
module text_screen_ctrl #(
    parameter int FRAMES_PER_SEC   = 60,
    parameter int COUNT_START      = 3,
    parameter int OVER_HOLD_FRAMES = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_frame,
    input  logic        btn_start,
    input  logic        crash,
    input  logic        start_on,
    input  logic [10:0] start_rom_addr,
    input  logic [2:0]  start_bit_addr,
    input  logic        cnt_on,
    input  logic [10:0] cnt_rom_addr,
    input  logic [2:0]  cnt_bit_addr,
    input  logic        over_on,
    input  logic [10:0] over_rom_addr,
    input  logic [2:0]  over_bit_addr,
    input  logic [7:0]  font_word,
    output logic        start_en,
    output logic        cnt_en,
    output logic        over_en,
    output logic        game_run,
    output logic [1:0]  cnt_digit,
    output logic [10:0] font_rom_addr,
    output logic        text_pixel
);

    localparam int FC_W = $clog2(FRAMES_PER_SEC + 1);
    localparam int HC_W = $clog2(OVER_HOLD_FRAMES + 1);

    typedef enum logic [1:0] {S_TITLE, S_COUNT, S_PLAY, S_OVER} state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic              btn_q;
    logic              text_on_q;
    logic [2:0]        bit_q;
    logic              press;
    logic              req_any;
    logic [2:0]        bit_sel;

    // btn_q resets high so a button held through reset is not seen as a press
    assign press = btn_start & ~btn_q;

    // State, counters, button history and the one-cycle overlay pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_TITLE;
            frame_cnt_q <= '0;
            hold_cnt_q  <= '0;
            digit_q     <= '0;
            btn_q       <= 1'b1;
            text_on_q   <= 1'b0;
            bit_q       <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            digit_q     <= digit_d;
            btn_q       <= btn_start;
            text_on_q   <= req_any;
            bit_q       <= bit_sel;
        end
    end

    // Screen sequencing: next state and counter updates
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        digit_d     = digit_q;
        unique case (state_q)
            S_TITLE: begin
                if (press) begin
                    state_d     = S_COUNT;
                    digit_d     = 2'(COUNT_START);
                    frame_cnt_d = '0;
                end
            end
            S_COUNT: begin
                if (tick_frame) begin
                    if (frame_cnt_q == FC_W'(FRAMES_PER_SEC - 1)) begin
                        frame_cnt_d = '0;
                        if (digit_q == 2'd1) begin
                            state_d = S_PLAY;
                            digit_d = 2'd0;
                        end else if (digit_q != 2'd0) begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (crash) begin
                    state_d    = S_OVER;
                    hold_cnt_d = '0;
                end
            end
            S_OVER: begin
                if (tick_frame && (hold_cnt_q != HC_W'(OVER_HOLD_FRAMES))) begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
                // presses before the hold expires are simply dropped
                if (press && (hold_cnt_q == HC_W'(OVER_HOLD_FRAMES))) begin
                    state_d = S_TITLE;
                end
            end
            default: state_d = S_TITLE;
        endcase
    end

    assign start_en  = (state_q == S_TITLE);
    assign cnt_en    = (state_q == S_COUNT);
    assign over_en   = (state_q == S_OVER);
    assign game_run  = (state_q == S_PLAY);
    assign cnt_digit = digit_q;

    // Fixed-priority font ROM arbiter: over > countdown > title
    always_comb begin
        font_rom_addr = 11'h000;
        bit_sel       = 3'd0;
        req_any       = 1'b0;
        if (over_on && over_en) begin
            font_rom_addr = over_rom_addr;
            bit_sel       = over_bit_addr;
            req_any       = 1'b1;
        end else if (cnt_on && cnt_en) begin
            font_rom_addr = cnt_rom_addr;
            bit_sel       = cnt_bit_addr;
            req_any       = 1'b1;
        end else if (start_on && start_en) begin
            font_rom_addr = start_rom_addr;
            bit_sel       = start_bit_addr;
            req_any       = 1'b1;
        end
    end

    // Glyph column 0 is the MSB of the font word
    assign text_pixel = text_on_q & font_word[~bit_q];

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Self-checking bench for text_screen_ctrl: directed sequences, a vector
// table for the arbiter/pixel path and randomized traffic, all compared
// against a behavioural model of the screen flow.
module tb_text_screen_ctrl;

    localparam int FPS  = 4;
    localparam int CS   = 3;
    localparam int HOLD = 2;

    localparam int M_TITLE = 0;
    localparam int M_COUNT = 1;
    localparam int M_PLAY  = 2;
    localparam int M_OVER  = 3;

    logic        clk = 1'b0;
    logic        reset_n, tick_frame, btn_start, crash;
    logic        start_on, cnt_on, over_on;
    logic [10:0] start_rom_addr, cnt_rom_addr, over_rom_addr;
    logic [2:0]  start_bit_addr, cnt_bit_addr, over_bit_addr;
    logic [7:0]  font_word;
    logic        start_en, cnt_en, over_en, game_run, text_pixel;
    logic [1:0]  cnt_digit;
    logic [10:0] font_rom_addr;

    always #5 clk = ~clk;

    text_screen_ctrl #(
        .FRAMES_PER_SEC  (FPS),
        .COUNT_START     (CS),
        .OVER_HOLD_FRAMES(HOLD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .tick_frame    (tick_frame),
        .btn_start     (btn_start),
        .crash         (crash),
        .start_on      (start_on),
        .start_rom_addr(start_rom_addr),
        .start_bit_addr(start_bit_addr),
        .cnt_on        (cnt_on),
        .cnt_rom_addr  (cnt_rom_addr),
        .cnt_bit_addr  (cnt_bit_addr),
        .over_on       (over_on),
        .over_rom_addr (over_rom_addr),
        .over_bit_addr (over_bit_addr),
        .font_word     (font_word),
        .start_en      (start_en),
        .cnt_en        (cnt_en),
        .over_en       (over_en),
        .game_run      (game_run),
        .cnt_digit     (cnt_digit),
        .font_rom_addr (font_rom_addr),
        .text_pixel    (text_pixel)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: screen, total ticks seen in COUNT/OVER, pixel pipe
    int scr;
    int cnt_ticks;
    int over_ticks;
    bit prev_btn;
    bit m_on;
    int m_bit;

    typedef struct {
        bit        s_on;
        bit [2:0]  s_bit;
        bit        c_on;
        bit        o_on;
        bit [7:0]  fw;
        bit [10:0] exp_addr;
        bit        exp_pix;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_sel();
        if (over_on && scr == M_OVER) return 3;
        else if (cnt_on && scr == M_COUNT) return 2;
        else if (start_on && scr == M_TITLE) return 1;
        else return 0;
    endfunction

    function automatic logic [10:0] model_addr();
        case (model_sel())
            3: return over_rom_addr;
            2: return cnt_rom_addr;
            1: return start_rom_addr;
            default: return 11'h000;
        endcase
    endfunction

    function automatic int model_bit();
        case (model_sel())
            3: return int'(over_bit_addr);
            2: return int'(cnt_bit_addr);
            1: return int'(start_bit_addr);
            default: return 0;
        endcase
    endfunction

    task automatic check_all();
        int exp_digit;
        int exp_pix;
        exp_digit = (scr == M_COUNT) ? CS - cnt_ticks / FPS : 0;
        exp_pix   = m_on ? ((int'(font_word) >> (7 - m_bit)) & 1) : 0;
        chk("start_en", start_en, scr == M_TITLE);
        chk("cnt_en", cnt_en, scr == M_COUNT);
        chk("over_en", over_en, scr == M_OVER);
        chk("game_run", game_run, scr == M_PLAY);
        chk("cnt_digit", cnt_digit, exp_digit);
        chk("font_rom_addr", font_rom_addr, model_addr());
        chk("text_pixel", text_pixel, exp_pix);
    endtask

    task automatic model_edge();
        bit press;
        bit ready;
        bit nxt_on;
        int nxt_bit;
        if (!reset_n) begin
            scr = M_TITLE; prev_btn = 1'b1; m_on = 1'b0; m_bit = 0;
            cnt_ticks = 0; over_ticks = 0;
        end else begin
            press   = btn_start && !prev_btn;
            nxt_on  = (model_sel() != 0);
            nxt_bit = model_bit();
            case (scr)
                M_TITLE: if (press) begin scr = M_COUNT; cnt_ticks = 0; end
                M_COUNT: if (tick_frame) begin
                    cnt_ticks++;
                    if (cnt_ticks == CS * FPS) scr = M_PLAY;
                end
                M_PLAY: if (crash) begin scr = M_OVER; over_ticks = 0; end
                default: begin
                    ready = (over_ticks >= HOLD);
                    if (tick_frame) over_ticks++;
                    if (press && ready) scr = M_TITLE;
                end
            endcase
            prev_btn = btn_start;
            m_on     = nxt_on;
            m_bit    = nxt_bit;
        end
    endtask

    // Inputs are already driven; check mid-cycle, then cross the edge
    task automatic step();
        #4;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_step(input bit tk, input bit b, input bit cr);
        tick_frame = tk;
        btn_start  = b;
        crash      = cr;
        step();
    endtask

    task automatic overlays_off();
        start_on = 1'b0; cnt_on = 1'b0; over_on = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1'b1, 3'd0, 1'b0, 1'b0, 8'h00, 11'h531, 1'b0};
        vecs[1] = '{1'b1, 3'd7, 1'b0, 1'b0, 8'h80, 11'h531, 1'b1};
        vecs[2] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h80, 11'h000, 1'b0};
        vecs[3] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'hFF, 11'h000, 1'b0};
        vecs[4] = '{1'b1, 3'd7, 1'b1, 1'b1, 8'hFF, 11'h531, 1'b0};
        vecs[5] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h01, 11'h000, 1'b1};
        vecs[6] = '{1'b1, 3'd3, 1'b0, 1'b0, 8'h00, 11'h531, 1'b0};
        vecs[7] = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h10, 11'h000, 1'b1};

        reset_n = 1'b0; tick_frame = 1'b0; btn_start = 1'b1; crash = 1'b0;
        overlays_off();
        start_rom_addr = 11'h531; cnt_rom_addr = 11'h332; over_rom_addr = 11'h471;
        start_bit_addr = 3'd0; cnt_bit_addr = 3'd0; over_bit_addr = 3'd0;
        font_word = 8'h00;
        @(posedge clk);
        @(posedge clk);
        model_edge();
        #1;

        // Button held through reset is not a press
        do_step(0, 1, 0);
        reset_n = 1'b1;
        do_step(0, 1, 0);
        do_step(0, 1, 0);
        chk("held_through_reset", start_en, 1);
        do_step(0, 0, 0);
        do_step(0, 1, 0);
        chk("press_cnt_en", cnt_en, 1);
        chk("press_digit", cnt_digit, 3);

        // Crash in COUNT is ignored
        do_step(0, 1, 1);
        chk("crash_in_count", {cnt_en, game_run, over_en}, 3'b100);

        // Countdown timing
        for (int t = 1; t <= 12; t++) begin
            do_step(1, 1, 0);
            if (t == 4)  chk("digit_after_4", cnt_digit, 2);
            if (t == 8)  chk("digit_after_8", cnt_digit, 1);
            if (t == 11) chk("still_count_11", cnt_en, 1);
            if (t == 12) chk("play_after_12", {game_run, cnt_digit}, 3'b100);
            do_step(0, 1, 0);
        end

        // Presses ignored in PLAY; crash ends the game
        do_step(0, 0, 0);
        do_step(0, 1, 0);
        chk("press_in_play", game_run, 1);
        do_step(0, 0, 0);
        do_step(0, 0, 1);
        chk("crash_over", {over_en, game_run}, 2'b10);

        // OVER hold
        do_step(1, 0, 0);
        do_step(0, 1, 0);
        chk("early_press_dropped", over_en, 1);
        do_step(0, 0, 0);
        do_step(1, 0, 0);
        do_step(0, 1, 0);
        chk("press_after_hold", start_en, 1);
        do_step(0, 0, 0);

        // Arbiter/pixel vectors in TITLE
        for (int i = 0; i < 8; i++) begin
            start_on = vecs[i].s_on; start_bit_addr = vecs[i].s_bit;
            cnt_on = vecs[i].c_on; over_on = vecs[i].o_on;
            font_word = vecs[i].fw;
            #3;
            chk($sformatf("vec%0d_addr", i), font_rom_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_pixel", i), text_pixel, vecs[i].exp_pix);
            do_step(0, 0, 0);
        end

        // Arbitration in COUNT and OVER with every overlay requesting
        do_step(0, 1, 0);
        start_on = 1'b1; cnt_on = 1'b1; over_on = 1'b1;
        #1;
        chk("arb_count_over_disabled", font_rom_addr, 11'h332);
        for (int t = 0; t < CS * FPS; t++) do_step(1, 1, 0);
        do_step(0, 1, 1);
        #1;
        chk("arb_over_wins", font_rom_addr, 11'h471);
        over_on = 1'b0;
        #1;
        chk("arb_drop_over", font_rom_addr, 11'h000);
        do_step(0, 1, 0);

        // Reset mid-operation
        reset_n = 1'b0;
        do_step(0, 1, 0);
        reset_n = 1'b1;
        chk("reset_mid_op", {start_en, over_en, cnt_digit}, 4'b1000);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            reset_n        = ($urandom_range(0, 299) != 0);
            tick_frame     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) btn_start = ~btn_start;
            crash          = ($urandom_range(0, 19) == 0);
            start_on       = 1'($urandom);
            cnt_on         = 1'($urandom);
            over_on        = 1'($urandom);
            start_rom_addr = 11'($urandom);
            cnt_rom_addr   = 11'($urandom);
            over_rom_addr  = 11'($urandom);
            start_bit_addr = 3'($urandom);
            cnt_bit_addr   = 3'($urandom);
            over_bit_addr  = 3'($urandom);
            font_word      = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
